// File: rtl/apb_group_master.sv
// apb_group_master: single-outstanding APB master bridge fanning out to NUM_SLV slaves.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_req_*/o_req_ready     request channel (addr, write, wdata, strb)
//   o_rsp_*/i_rsp_ready     response channel (rdata, err)
//   o_psel..o_pstrb         APB master outputs (one-hot psel per slave)
//   i_prdata/i_pready/i_pslverr  per-slave APB returns, slave k at slice k
module apb_group_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_SLV = 4,
  parameter int unsigned SLV_AW  = 12,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic [ADDR_W-1:0]         i_req_addr,
  input  logic                      i_req_write,
  input  logic [DATA_W-1:0]         i_req_wdata,
  input  logic [DATA_W/8-1:0]       i_req_strb,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [DATA_W-1:0]         o_rsp_rdata,
  output logic                      o_rsp_err,
  output logic [NUM_SLV-1:0]        o_psel,
  output logic                      o_penable,
  output logic [ADDR_W-1:0]         o_paddr,
  output logic                      o_pwrite,
  output logic [DATA_W-1:0]         o_pwdata,
  output logic [DATA_W/8-1:0]       o_pstrb,
  input  logic [NUM_SLV*DATA_W-1:0] i_prdata,
  input  logic [NUM_SLV-1:0]        i_pready,
  input  logic [NUM_SLV-1:0]        i_pslverr
);

  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned IDX_W   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int unsigned CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cap_addr_q, cap_addr_d;
  logic                cap_write_q, cap_write_d;
  logic [DATA_W-1:0]   cap_wdata_q, cap_wdata_d;
  logic [STRB_W-1:0]   cap_strb_q, cap_strb_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                req_ready_d, rsp_valid_d, rsp_err_d, penable_d, pwrite_d;
  logic [DATA_W-1:0]   rsp_rdata_d, pwdata_d;
  logic [NUM_SLV-1:0]  psel_d;
  logic [ADDR_W-1:0]   paddr_d;
  logic [STRB_W-1:0]   pstrb_d;

  logic                accept_c, dec_err_c, timeout_c, apb_on_c;
  logic                sel_ready_c, sel_err_c;
  logic [DATA_W-1:0]   sel_rdata_c;
  logic [IDX_W-1:0]    cap_idx_c;

  // Whole upper address field is decoded so aliases of a valid index still miss.
  assign accept_c  = (state_q == IDLE) && o_req_ready && i_req_valid;
  assign dec_err_c = (i_req_addr >> SLV_AW) >= ADDR_W'(NUM_SLV);
  assign cap_idx_c = cap_addr_q[SLV_AW +: IDX_W];

  // Return mux: only the addressed slave's ready/err/rdata are observed.
  always_comb begin
    sel_ready_c = 1'b0;
    sel_err_c   = 1'b0;
    sel_rdata_c = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (cap_idx_c == IDX_W'(k)) begin
        sel_ready_c = i_pready[k];
        sel_err_c   = i_pslverr[k];
        sel_rdata_c = i_prdata[k*DATA_W +: DATA_W];
      end
    end
  end

  // pready in the final permitted ACCESS cycle takes precedence over the abort.
  assign timeout_c = (TIMEOUT != 0) && (state_q == ACCESS) && !sel_ready_c &&
                     (cnt_q == CNT_W'(TO_LAST));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = dec_err_c ? RESP : SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (sel_ready_c || timeout_c) state_d = RESP;
      RESP:    if (i_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values; outputs track the state being entered.
  always_comb begin
    cap_addr_d  = cap_addr_q;
    cap_write_d = cap_write_q;
    cap_wdata_d = cap_wdata_q;
    cap_strb_d  = cap_strb_q;
    rsp_rdata_d = o_rsp_rdata;
    rsp_err_d   = o_rsp_err;
    cnt_d       = '0;

    if (accept_c) begin
      cap_addr_d  = i_req_addr;
      cap_write_d = i_req_write;
      cap_wdata_d = i_req_wdata;
      cap_strb_d  = i_req_strb;
    end

    if (state_q == ACCESS && state_d == ACCESS) cnt_d = cnt_q + CNT_W'(1);

    if (accept_c && dec_err_c) begin
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b1;
    end else if (state_q == ACCESS && sel_ready_c) begin
      rsp_rdata_d = cap_write_q ? '0 : sel_rdata_c;
      rsp_err_d   = sel_err_c;
    end else if (timeout_c) begin
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b1;
    end else if (state_d == IDLE) begin
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;
    end

    apb_on_c    = (state_d == SETUP) || (state_d == ACCESS);
    psel_d      = apb_on_c ? (NUM_SLV'(1) << cap_addr_d[SLV_AW +: IDX_W]) : '0;
    penable_d   = (state_d == ACCESS);
    paddr_d     = apb_on_c ? cap_addr_d : '0;
    pwrite_d    = apb_on_c && cap_write_d;
    pwdata_d    = apb_on_c ? cap_wdata_d : '0;
    pstrb_d     = (apb_on_c && cap_write_d) ? cap_strb_d : '0;
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  // Output and capture registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cap_addr_q  <= '0;
      cap_write_q <= 1'b0;
      cap_wdata_q <= '0;
      cap_strb_q  <= '0;
      cnt_q       <= '0;
      o_req_ready <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
      o_psel      <= '0;
      o_penable   <= 1'b0;
      o_paddr     <= '0;
      o_pwrite    <= 1'b0;
      o_pwdata    <= '0;
      o_pstrb     <= '0;
    end else begin
      cap_addr_q  <= cap_addr_d;
      cap_write_q <= cap_write_d;
      cap_wdata_q <= cap_wdata_d;
      cap_strb_q  <= cap_strb_d;
      cnt_q       <= cnt_d;
      o_req_ready <= req_ready_d;
      o_rsp_valid <= rsp_valid_d;
      o_rsp_rdata <= rsp_rdata_d;
      o_rsp_err   <= rsp_err_d;
      o_psel      <= psel_d;
      o_penable   <= penable_d;
      o_paddr     <= paddr_d;
      o_pwrite    <= pwrite_d;
      o_pwdata    <= pwdata_d;
      o_pstrb     <= pstrb_d;
    end
  end

endmodule
